alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Initiator that drives the 8-bit ALU datapath (operand muxes, accumulator/input registers, one-hot output mux, overflow flag).
- Accepts one operation per command over a valid/ready handshake and encodes it onto the ALU's one-hot selectors and operands.
- Waits for the registered datapath to settle, captures result and overflow, and returns them over a valid/ready response channel.
- Sits between a host/test controller and the ALU top.

Parameters:
- WIDTH, 8, operand/result width.
- SETTLE_CYCLES, 1, cycles after the issue edge before alu_result is sampled; legal range 1-15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0=AND 1=OR 2=XOR 3=NOT 4=ADD 5=SUB 6=MULT 7=CLEAR.
- cmd_chain  in  1  1: operand A = last captured result; 0: operand A = cmd_a.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- alu_on  out  1  ALU power/enable.
- alu_in_sel  out  3  one-hot: [2]=persist, [1]=load, [0]=reset.
- alu_out_sel  out  7  one-hot: [6]=and [5]=or [4]=not [3]=xor [2]=add [1]=sub [0]=mult.
- alu_num1  out  WIDTH  operand A to ALU.
- alu_num2  out  WIDTH  operand B to ALU.
- alu_result  in  WIDTH  ALU outputVal.
- alu_overflow  in  1  ALU multiply overflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured result.
- rsp_error  out  1  overflow at capture.
- err_sticky  out  1  set by any overflowed response; cleared by CLEAR.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (async on rst_n low):
  - state=IDLE, cmd_ready=1, alu_on=0, alu_in_sel=3'b010, alu_out_sel=7'b0000100 (add).
  - alu_num1=0, alu_num2=0, rsp_valid=0, rsp_data=0, rsp_error=0, err_sticky=0, last_result=0, busy=0.
- alu_on rises on the first clock after reset release and stays 1.
- FSM states: IDLE, ISSUE, SETTLE, RESPOND.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op/operands and drive alu_num1 = cmd_chain ? last_result : cmd_a, alu_num2=cmd_b.
  - Drive alu_out_sel = one-hot of op, and alu_in_sel=load (reset for CLEAR). Go to ISSUE.
  - While waiting, selectors and operands hold their previous values so the ALU registers reload stable data.
- ISSUE: one cycle; ALU registers capture on this edge. Go to SETTLE, counter = SETTLE_CYCLES-1.
- SETTLE: decrement counter. At 0, sample alu_result/alu_overflow into rsp_data/rsp_error and last_result. Go to RESPOND.
- CLEAR:
  - Uses alu_in_sel=reset (3'b001).
  - Response data forced to 0, rsp_error=0.
  - last_result=0 and err_sticky=0.
- RESPOND:
  - rsp_valid=1; rsp_data/rsp_error stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid=0, return to IDLE; cmd_ready rises the same edge.
  - err_sticky set on that handshake if rsp_error=1.
- cmd_ready=0 in all states except IDLE; no command accepted while a response is pending.
- Command-to-response latency: 1 (ISSUE) + SETTLE_CYCLES cycles after the accept edge, rsp_valid asserts. Default: rsp_valid high 2 cycles after acceptance.
- persist is never driven; alu_in_sel is always one-hot load or reset.
- Result width is truncated to WIDTH by the ALU. The sequencer does not modify data except for CLEAR.
- Reset mid-operation: all state abandoned, values above restored, no response emitted.
- cmd_valid while busy: ignored (held by initiator per handshake).
- rsp_ready high before rsp_valid: no effect.

Decomposition:
- Shared package alu_pkg:
  - Op encodings OP_AND..OP_CLEAR.
  - IN_PERSIST/IN_LOAD/IN_RESET one-hot constants.
  - OUT_AND..OUT_MULT one-hot constants.
  - FSM state encodings.
- One natural sub-module: alu_op_encoder (combinational op -> alu_out_sel/alu_in_sel).

Test Plan:
- ADD a=8'h30 b=8'h12 chain=0 -> rsp_data=8'h42, rsp_error=0, rsp_valid 2 cycles after accept, alu_out_sel=7'b0000100.
- Chained SUB after previous: chain=1 b=8'h02 -> alu_num1=8'h42, rsp_data=8'h40.
- MULT a=8'h20 b=8'h10 -> rsp_data=8'h00, rsp_error=1, err_sticky=1 after handshake; then CLEAR -> rsp_data=8'h00, err_sticky=0, alu_in_sel=3'b001 during issue.
- Backpressure: rsp_ready low 5 cycles -> rsp_valid/rsp_data held constant, cmd_ready=0 throughout, second cmd_valid ignored until handshake.
- rst_n low during SETTLE of XOR 8'hF0^8'h0F -> outputs immediately at reset values, no response; post-reset NOT a=8'hAA -> rsp_data=8'h55.
- SETTLE_CYCLES=3 build: AND 8'hCC&8'hAA -> rsp_data=8'h88, rsp_valid exactly 4 cycles after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command sequencer: op codes, one-hot ALU
// selector constants and the sequencer FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NOT   = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_MULT  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [2:0] IN_PERSIST = 3'b100;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_RESET   = 3'b001;

    localparam logic [6:0] OUT_AND  = 7'b1000000;
    localparam logic [6:0] OUT_OR   = 7'b0100000;
    localparam logic [6:0] OUT_NOT  = 7'b0010000;
    localparam logic [6:0] OUT_XOR  = 7'b0001000;
    localparam logic [6:0] OUT_ADD  = 7'b0000100;
    localparam logic [6:0] OUT_SUB  = 7'b0000010;
    localparam logic [6:0] OUT_MULT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_RESPOND = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_op_encoder.sv
// Combinational mapping of a command op code onto the ALU's one-hot output
// and input-register selectors.
module alu_op_encoder
    import alu_pkg::*;
(
    input  logic [2:0] op_i,
    output logic [6:0] out_sel_o,
    output logic [2:0] in_sel_o
);

    // CLEAR keeps the add path selected and resets the ALU registers instead of loading
    always_comb begin
        out_sel_o = OUT_ADD;
        in_sel_o  = IN_LOAD;
        case (op_i)
            OP_AND:   out_sel_o = OUT_AND;
            OP_OR:    out_sel_o = OUT_OR;
            OP_XOR:   out_sel_o = OUT_XOR;
            OP_NOT:   out_sel_o = OUT_NOT;
            OP_ADD:   out_sel_o = OUT_ADD;
            OP_SUB:   out_sel_o = OUT_SUB;
            OP_MULT:  out_sel_o = OUT_MULT;
            OP_CLEAR: begin
                out_sel_o = OUT_ADD;
                in_sel_o  = IN_RESET;
            end
            default: begin
                out_sel_o = OUT_ADD;
                in_sel_o  = IN_LOAD;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command/response front end for the registered 8-bit ALU: encodes one op per
// command, waits for the datapath to settle, and returns result and overflow.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_chain,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             alu_on,
    output logic [2:0]       alu_in_sel,
    output logic [6:0]       alu_out_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic             err_sticky,
    output logic             busy
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] num1_q, num1_d, num2_q, num2_d;
    logic [6:0]       out_sel_q, out_sel_d;
    logic [2:0]       in_sel_q, in_sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d, last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic             sticky_q, sticky_d, cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d, alu_on_q;
    logic [6:0]       enc_out_sel_s;
    logic [2:0]       enc_in_sel_s;

    alu_op_encoder u_enc (
        .op_i      (cmd_op),
        .out_sel_o (enc_out_sel_s),
        .in_sel_o  (enc_in_sel_s)
    );

    // State and output registers; everything is restored on reset so no response survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            op_q        <= OP_ADD;
            num1_q      <= '0;
            num2_q      <= '0;
            out_sel_q   <= OUT_ADD;
            in_sel_q    <= IN_LOAD;
            rsp_data_q  <= '0;
            last_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            sticky_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            alu_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            out_sel_q   <= out_sel_d;
            in_sel_q    <= in_sel_d;
            rsp_data_q  <= rsp_data_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            sticky_q    <= sticky_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            alu_on_q    <= 1'b1;
        end
    end

    // Next-state logic; selectors and operands hold between commands so the ALU reloads stable data
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        out_sel_d   = out_sel_q;
        in_sel_d    = in_sel_q;
        rsp_data_d  = rsp_data_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        sticky_d    = sticky_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d      = cmd_op;
                    num1_d    = cmd_chain ? last_q : cmd_a;
                    num2_d    = cmd_b;
                    out_sel_d = enc_out_sel_s;
                    in_sel_d  = enc_in_sel_s;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = SETTLE_INIT;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    if (op_q == OP_CLEAR) begin
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b0;
                        last_d      = '0;
                        sticky_d    = 1'b0;
                    end else begin
                        rsp_data_d  = alu_result;
                        rsp_error_d = alu_overflow;
                        last_d      = alu_result;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    sticky_d    = sticky_q | rsp_error_q;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESPOND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign alu_on      = alu_on_q;
    assign alu_in_sel  = in_sel_q;
    assign alu_out_sel = out_sel_q;
    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural registered ALU
// model behind each instance (default settle and a SETTLE_CYCLES=3 build).
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0, cmd_chain = 1'b0, rsp_ready = 1'b1;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_a = 8'h00, cmd_b = 8'h00;
    logic       cmd_ready, alu_on, alu_overflow, rsp_valid, rsp_error, err_sticky, busy;
    logic [2:0] alu_in_sel;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_num1, alu_num2, alu_result, rsp_data;

    logic       t3_cmd_valid = 1'b0, t3_rsp_ready = 1'b1;
    logic [2:0] t3_cmd_op = 3'd0;
    logic [7:0] t3_cmd_a = 8'h00, t3_cmd_b = 8'h00;
    logic       t3_cmd_ready, t3_alu_on, t3_ovf, t3_rsp_valid, t3_rsp_error, t3_sticky, t3_busy;
    logic [2:0] t3_in_sel;
    logic [6:0] t3_out_sel;
    logic [7:0] t3_num1, t3_num2, t3_result, t3_rsp_data;

    int checks = 0;
    int failures = 0;
    logic [8:0] sb_q[$];

    alu_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_out_sel(alu_out_sel),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .err_sticky(err_sticky), .busy(busy)
    );

    alu_cmd_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(t3_cmd_valid), .cmd_ready(t3_cmd_ready),
        .cmd_op(t3_cmd_op), .cmd_chain(1'b0), .cmd_a(t3_cmd_a), .cmd_b(t3_cmd_b),
        .alu_on(t3_alu_on), .alu_in_sel(t3_in_sel), .alu_out_sel(t3_out_sel),
        .alu_num1(t3_num1), .alu_num2(t3_num2), .alu_result(t3_result),
        .alu_overflow(t3_ovf), .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready),
        .rsp_data(t3_rsp_data), .rsp_error(t3_rsp_error), .err_sticky(t3_sticky), .busy(t3_busy)
    );

    function automatic logic [8:0] alu_fn(input logic [6:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        case (sel)
            7'b1000000: return {1'b0, a & b};
            7'b0100000: return {1'b0, a | b};
            7'b0010000: return {1'b0, ~a};
            7'b0001000: return {1'b0, a ^ b};
            7'b0000100: return {1'b0, a + b};
            7'b0000010: return {1'b0, a - b};
            7'b0000001: return {|p[15:8], p[7:0]};
            default:    return 9'd0;
        endcase
    endfunction

    logic [7:0] ra, rb, ra3, rb3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= 8'h00; rb <= 8'h00; ra3 <= 8'h00; rb3 <= 8'h00;
        end else begin
            if (alu_in_sel == 3'b001) begin ra <= 8'h00; rb <= 8'h00; end
            else if (alu_in_sel == 3'b010) begin ra <= alu_num1; rb <= alu_num2; end
            if (t3_in_sel == 3'b001) begin ra3 <= 8'h00; rb3 <= 8'h00; end
            else if (t3_in_sel == 3'b010) begin ra3 <= t3_num1; rb3 <= t3_num2; end
        end
    end
    assign {alu_overflow, alu_result} = alu_fn(alu_out_sel, ra, rb);
    assign {t3_ovf, t3_result}        = alu_fn(t3_out_sel, ra3, rb3);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted response is compared against the oldest expectation
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_data", rsp_data, e[7:0]);
                    chk("rsp_error", rsp_error, e[8]);
                end
            end
        end
    end

    task automatic send(input string nm, input logic [2:0] op, input logic ch,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_d,
                        input logic exp_e, input logic [7:0] exp_n1, input logic [6:0] exp_os,
                        input logic [2:0] exp_is);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_ready_timeout"}, cmd_ready, 1);
        sb_q.push_back({exp_e, exp_d});
        cmd_op = op; cmd_chain = ch; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({nm, "_num1"}, alu_num1, exp_n1);
        chk({nm, "_out_sel"}, alu_out_sel, exp_os);
        chk({nm, "_in_sel"}, alu_in_sel, exp_is);
        chk({nm, "_busy_ready"}, {busy, cmd_ready}, 2'b10);
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, n, 2);
        n = 0;
        while (rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_hs_timeout"}, rsp_valid, 0);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_ready_on_busy", {cmd_ready, alu_on, busy}, 3'b100);
        chk("rst_in_sel", alu_in_sel, 3'b010);
        chk("rst_out_sel", alu_out_sel, 7'b0000100);
        chk("rst_nums", {alu_num1, alu_num2}, 16'h0000);
        chk("rst_rsp", {rsp_valid, rsp_error, err_sticky, rsp_data}, 11'h000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("alu_on_rise", alu_on, 1);

        send("add",  OP_ADD,  1'b0, 8'h30, 8'h12, 8'h42, 1'b0, 8'h30, OUT_ADD,  IN_LOAD);
        send("sub",  OP_SUB,  1'b1, 8'h99, 8'h02, 8'h40, 1'b0, 8'h42, OUT_SUB,  IN_LOAD);
        chk("sticky_pre", err_sticky, 0);
        send("mult", OP_MULT, 1'b0, 8'h20, 8'h10, 8'h00, 1'b1, 8'h20, OUT_MULT, IN_LOAD);
        chk("sticky_set", err_sticky, 1);
        send("clr",  OP_CLEAR, 1'b0, 8'h55, 8'h66, 8'h00, 1'b0, 8'h55, OUT_ADD, IN_RESET);
        chk("sticky_clr", err_sticky, 0);

        // Backpressure with a second command waiting
        rsp_ready = 1'b0;
        sb_q.push_back({1'b0, 8'h3F});
        cmd_op = OP_OR; cmd_chain = 1'b0; cmd_a = 8'h0F; cmd_b = 8'h30; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_latency", n, 2);
        sb_q.push_back({1'b0, 8'h02});
        cmd_op = OP_ADD; cmd_a = 8'h01; cmd_b = 8'h01; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", {rsp_valid, cmd_ready, busy, rsp_data}, {3'b101, 8'h3F});
            chk("bp_ignored", alu_num1, 8'h0F);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {rsp_valid, cmd_ready}, 2'b01);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_second_accept", {alu_num1, alu_out_sel}, {8'h01, OUT_ADD});
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        n = 0;
        while (rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_done", rsp_valid, 0);

        // Reset while the XOR is settling; no response may follow
        cmd_op = OP_XOR; cmd_a = 8'hF0; cmd_b = 8'h0F; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {cmd_ready, busy, alu_on, rsp_valid}, 4'b1000);
        chk("mid_rst_sel", {alu_in_sel, alu_out_sel}, {3'b010, 7'b0000100});
        chk("mid_rst_data", {alu_num1, alu_num2, rsp_data}, 24'h000000);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; chk("mid_no_rsp", rsp_valid, 0); end
        send("not", OP_NOT, 1'b0, 8'hAA, 8'h00, 8'h55, 1'b0, 8'hAA, OUT_NOT, IN_LOAD);

        // Long-settle build
        t3_cmd_op = OP_AND; t3_cmd_a = 8'hCC; t3_cmd_b = 8'hAA; t3_cmd_valid = 1'b1;
        chk("t3_ready", t3_cmd_ready, 1);
        @(posedge clk); #1;
        t3_cmd_valid = 1'b0;
        n = 0;
        while (!t3_rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
        chk("t3_latency", n, 4);
        chk("t3_rsp", {t3_rsp_error, t3_rsp_data}, {1'b0, 8'h88});
        @(posedge clk); #1;
        chk("t3_hs", {t3_rsp_valid, t3_cmd_ready}, 2'b01);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
